// File: rtl/psdu_byte_packer.sv
// psdu_byte_packer: packs LSB-first PSDU bits into octets and queues them in a FWFT FIFO.
module psdu_byte_packer #(
  parameter int FIFO_DEPTH   = 8,
  parameter int LENGTH_WIDTH = 12
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [LENGTH_WIDTH-1:0] i_length,
  input  logic                    i_bit,
  input  logic                    i_bit_valid,
  output logic [7:0]              o_byte,
  output logic                    o_byte_valid,
  input  logic                    i_byte_ready,
  output logic                    o_byte_last,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;
  state_t                  r_state;
  logic [LENGTH_WIDTH-1:0] r_len;
  logic [LENGTH_WIDTH-1:0] r_oct;
  logic [2:0]              r_bcnt;
  logic [7:0]              r_sr;
  logic                    r_done;
  logic                    r_overflow;
  logic [8:0]              r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr;
  logic [AW-1:0]           r_rd;
  logic [AW:0]             r_cnt;
  logic                    w_go;
  logic                    w_shift;
  logic                    w_push;
  logic                    w_last;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_wr;
  logic                    w_drained;
  logic [7:0]              w_byte;
  assign w_go      = (r_state == IDLE) && i_start && (|i_length);
  // A bit arriving with the accepted Start is already the first PSDU bit.
  assign w_shift   = ((r_state == PACK) || w_go) && i_bit_valid;
  assign w_push    = w_shift && (&r_bcnt);
  assign w_byte    = {i_bit, r_sr[7:1]};
  assign w_last    = (r_oct == r_len - 1'b1);
  assign w_pop     = o_byte_valid && i_byte_ready;
  assign w_full    = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_drained = (r_cnt == '0) || ((r_cnt == (AW+1)'(1)) && w_pop);
  assign o_byte_valid = |r_cnt;
  assign o_byte       = o_byte_valid ? r_mem[r_rd][7:0] : 8'h00;
  assign o_byte_last  = o_byte_valid && r_mem[r_rd][8];
  assign o_busy       = (r_state != IDLE);
  assign o_done       = r_done;
  assign o_overflow   = r_overflow;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_oct      <= '0;
      r_bcnt     <= '0;
      r_sr       <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_shift) begin
        r_sr   <= w_byte;
        r_bcnt <= r_bcnt + 3'd1;
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_push && !w_last) r_oct <= r_oct + 1'b1;
      case (r_state)
        IDLE:
          if (w_go) begin
            r_state    <= PACK;
            r_len      <= i_length;
            r_oct      <= '0;
            r_overflow <= 1'b0;
          end else if (i_start) r_done <= 1'b1;
        PACK:
          if (w_push && w_last) r_state <= DRAIN;
        DRAIN:
          if (w_drained) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        default: r_state <= IDLE;
      endcase
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
    end
  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge i_clk)
    if (w_wr) r_mem[r_wr] <= {w_last, w_byte};
endmodule

// File: tb/tb_psdu_byte_packer.sv
// tb_psdu_byte_packer: randomized and directed frames checked against a queue-based reference model.
module tb_psdu_byte_packer;
  localparam int DEPTH = 8;
  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [11:0] i_length;
  logic        i_bit;
  logic        i_bit_valid;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_byte_last;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;

  psdu_byte_packer #(.FIFO_DEPTH(DEPTH), .LENGTH_WIDTH(12)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_length(i_length),
    .i_bit(i_bit), .i_bit_valid(i_bit_valid), .o_byte(o_byte),
    .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
    .o_byte_last(o_byte_last), .o_busy(o_busy), .o_done(o_done),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int m_mode;
  int m_len;
  int m_nb;
  int m_no;
  logic [7:0] m_acc;
  bit m_ovf;
  bit m_done;
  logic [8:0] m_q[$];
  logic [7:0] bq[$];
  int n_pop;
  int n_last;
  int n_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", o_byte_valid, m_q.size() != 0);
    if (m_q.size() != 0 && o_byte_valid) begin
      chk("byte", o_byte, m_q[0][7:0]);
      chk("last", o_byte_last, m_q[0][8]);
    end
    chk("busy", o_busy, m_mode != 0);
    chk("done", o_done, m_done);
    chk("overflow", o_overflow, m_ovf);
  endtask

  task automatic model_clear();
    m_mode = 0;
    m_q.delete();
    m_ovf  = 0;
    m_done = 0;
    m_nb   = 0;
    m_no   = 0;
    m_acc  = 8'h00;
  endtask

  task automatic clr_cnt();
    n_pop  = 0;
    n_last = 0;
    n_done = 0;
  endtask

  task automatic cyc(input bit st, input int ln, input bit b, input bit bv, input bit rdy);
    bit pop;
    bit push;
    int pm;
    logic [8:0] ent;
    i_start      = st;
    i_length     = ln[11:0];
    i_bit        = b;
    i_bit_valid  = bv;
    i_byte_ready = rdy;
    pop  = (m_q.size() > 0) && rdy;
    pm   = m_mode;
    push = 0;
    ent  = '0;
    @(posedge clk);
    #1;
    m_done = 0;
    if (m_mode == 0 && st) begin
      if (ln == 0) m_done = 1;
      else begin
        m_mode = 1;
        m_len  = ln;
        m_nb   = 0;
        m_no   = 0;
        m_acc  = 8'h00;
        m_ovf  = 0;
      end
    end
    if (m_mode == 1 && bv) begin
      m_acc[m_nb] = b;
      m_nb++;
      if (m_nb == 8) begin
        ent  = {m_no == m_len - 1, m_acc};
        m_no++;
        m_nb = 0;
        if (m_q.size() == DEPTH && !pop) m_ovf = 1;
        else push = 1;
        if (m_no == m_len) m_mode = 2;
      end
    end
    if (pop) begin
      n_pop++;
      if (m_q[0][8]) n_last++;
      void'(m_q.pop_front());
    end
    if (push) m_q.push_back(ent);
    if (pm == 2 && m_q.size() == 0) begin
      m_done = 1;
      m_mode = 0;
    end
    if (m_done) n_done++;
    check_outputs();
  endtask

  // vmode: 0 continuous, 1 every other cycle, 2 random; rmode: 0 ready, 1 stalled until bits sent, 2 random, 3 single pop on the final bit
  task automatic run_frame(input int len, input int vmode, input int rmode, input int maxbits);
    int total;
    int sent;
    int n;
    int budget;
    bit first;
    bit bv;
    bit rdy;
    bit st;
    logic [7:0] t;
    total = len * 8;
    sent  = 0;
    n     = 0;
    first = 1;
    while (sent < total && sent < maxbits) begin
      bv  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
      t   = bq[sent / 8];
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 :
            (rmode == 3) ? (sent == total - 1 && bv) : 1'($urandom_range(0, 1));
      st  = first ? 1'b1 : (vmode == 2 && $urandom_range(0, 15) == 0);
      cyc(st, first ? len : int'($urandom_range(0, 30)), t[sent % 8], bv, rdy);
      if (bv) sent++;
      first = 0;
      n++;
    end
    if (sent < total) return;
    budget = 300;
    while (m_mode != 0 && budget > 0) begin
      cyc(1'($urandom_range(0, 1)), 5, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1);
      budget--;
    end
    if (budget == 0) chk("drain_timeout", o_busy, 0);
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_start      = 0;
    i_length     = '0;
    i_bit        = 0;
    i_bit_valid  = 0;
    i_byte_ready = 0;
    i_rst_n      = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    clr_cnt();
    bq = '{8'hA5, 8'h3C};
    run_frame(2, 0, 0, 999);
    chk("basic_pops", n_pop, 2);
    chk("basic_last", n_last, 1);
    chk("basic_done", n_done, 1);

    clr_cnt();
    bq = '{8'h01, 8'h80, 8'hFF};
    run_frame(3, 1, 0, 999);
    chk("gap_pops", n_pop, 3);
    chk("gap_done", n_done, 1);

    clr_cnt();
    bq.delete();
    for (int i = 0; i < 10; i++) bq.push_back(8'($urandom));
    run_frame(10, 0, 1, 999);
    chk("ovf_pops", n_pop, 8);
    chk("ovf_last", n_last, 0);
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_done", n_done, 1);

    clr_cnt();
    cyc(1, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 1);
    chk("zero_done", n_done, 1);
    chk("zero_pops", n_pop, 0);

    clr_cnt();
    bq.delete();
    for (int i = 0; i < 9; i++) bq.push_back(8'($urandom));
    run_frame(9, 0, 3, 999);
    chk("full_pop_ovf", o_overflow, 0);
    chk("full_pop_pops", n_pop, 9);
    chk("full_pop_last", n_last, 1);

    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
    run_frame(4, 0, 0, 13);
    do_reset();
    clr_cnt();
    bq = '{8'h5A};
    run_frame(1, 0, 0, 999);
    chk("rst_pops", n_pop, 1);
    chk("rst_last", n_last, 1);
    chk("rst_done", n_done, 1);

    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(0, 20);
      clr_cnt();
      if (len == 0) begin
        cyc(1, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);
      end else begin
        bq.delete();
        for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
        run_frame(len, 2, 2, 999);
      end
      chk("rand_done", n_done, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/psdu_byte_packer.md
# psdu_byte_packer

Packs the descrambled serial PSDU bit stream from the 802.11a receiver into octets and hands them to the MAC side through a small FIFO with a valid/ready handshake. Sits directly downstream of the receiver/descrambler. Consumes one bit per qualified clock for exactly `Length` octets per frame, marks the final octet, and signals frame completion once every octet has been drained.

## Interface
- `FIFO_DEPTH`, default 8: output FIFO depth in octets; power of two, ≥2.
- `LENGTH_WIDTH`, default 12: width of the octet count (matches the SIGNAL LENGTH field).

- `Clock`, in, 1: the single clock; all logic on its rising edge.
- `Reset`, in, 1: asynchronous, active-low reset.
- `Start`, in, 1: one-cycle pulse marking the first PSDU bit slot. Latches `Length`.
- `Length`, in, LENGTH_WIDTH: PSDU octet count. Sampled only when `Start` is accepted.
- `Bit_in`, in, 1: descrambled data bit.
- `Bit_valid`, in, 1: qualifies `Bit_in` on this clock.
- `Byte_out`, out, 8: head-of-FIFO octet.
- `Byte_valid`, out, 1: FIFO not empty.
- `Byte_ready`, in, 1: consumer accepts `Byte_out` when `Byte_valid` and `Byte_ready` are both high.
- `Byte_last`, out, 1: head octet is the frame's final octet.
- `Busy`, out, 1: high whenever the FSM is not in IDLE.
- `Done`, out, 1: one-cycle pulse at frame completion.
- `Overflow`, out, 1: sticky flag; an octet was dropped because the FIFO was full.

## Operation
- **FSM states: IDLE, PACK, DRAIN.**
  - IDLE:
    - `Start` with `Length`≠0: latch `Length`, clear the bit counter, octet counter and `Overflow`, then go to PACK.
    - `Start` with `Length`=0: pulse `Done` next cycle and stay in IDLE.
  - PACK: each `Bit_valid` cycle shifts `Bit_in` into the assembly register. The first bit received is the LSB, bit 7 is the eighth.
    - 3-bit bit counter; on the 8th bit the completed octet is pushed to the FIFO.
    - The pushed octet's last tag = (octet counter == latched Length−1). The octet counter then increments.
    - After pushing the last octet, go to DRAIN.
  - DRAIN: when the FIFO is empty, pulse `Done` and return to IDLE.
- `Start` in PACK or DRAIN is ignored. `Bit_valid` in IDLE or DRAIN is ignored.
- FIFO: first-word-fall-through. Each entry is 9 bits (octet plus last tag). Read/write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo depth. The occupancy count is log2(FIFO_DEPTH)+1 bits.
- Push when full:
  - If a pop occurs the same cycle, the push is accepted.
  - Otherwise the octet is dropped and `Overflow` is set.
  - The octet counter still advances, so frame boundaries are preserved.
  - If the dropped octet is the last one, the FSM still enters DRAIN. `Byte_last` is then never seen; `Overflow` reports the loss.
- Simultaneous push and pop: occupancy is unchanged; both pointers advance.
- Counter arithmetic: octet counter is LENGTH_WIDTH bits and cannot wrap, because it stops at Length−1. The last-octet compare uses latched Length−1 and is only evaluated when Length≠0.

## Timing
- Reset values:
  - `Byte_out`=0, `Byte_valid`=0, `Byte_last`=0, `Busy`=0, `Done`=0, `Overflow`=0.
  - FSM in IDLE, FIFO empty, all counters 0.
- Reset asserted mid-frame: the frame is abandoned immediately, the FIFO is flushed, and no `Done` is issued.
- `Start` accepted at edge N: `Busy`=1 from N. A `Bit_valid` on the same cycle as `Start` is the first PSDU bit.
- Octet latency:
  - The 8th `Bit_valid` is sampled at edge M; `Byte_valid` rises after edge M (one-cycle latency) if the FIFO was empty.
  - A pop at edge P presents the next entry after edge P.
- `Done`: high for the one cycle after the edge at which the last entry pops (FIFO becomes empty in DRAIN). `Busy` falls in that same cycle.
- Sustained throughput: one octet per 8 `Bit_valid` cycles. No bubbles are required while the consumer holds `Byte_ready`=1.

## Test plan
- **Basic frame:** Length=2, continuous bits of 0xA5 then 0x3C (LSB first), `Byte_ready`=1.
  - Expect `Byte_out` A5 (`Byte_last`=0), then 3C (`Byte_last`=1); `Done` pulses once; `Overflow`=0.
- **Gapped input:** Length=3, bits of 0x01,0x80,0xFF with `Bit_valid` deasserted every other cycle.
  - Expect identical octets in order; each appears one cycle after its 8th valid bit.
- **Backpressure overflow:** FIFO_DEPTH=8, Length=10, `Byte_ready`=0 until all bits are sent, then 1.
  - Expect `Overflow`=1 after the 9th octet; exactly the first 8 octets are delivered; no `Byte_last`; `Done` after the 8th pop.
- **Zero length:** Start with Length=0.
  - Expect `Done` on the next cycle, `Busy` to stay 0, and no `Byte_valid`.
- **Full with simultaneous pop:** fill the FIFO to 8 entries, then complete a 9th octet on the same cycle as a pop.
  - Expect no overflow and occupancy to remain 8.
- **Reset mid-frame:** Length=4; assert `Reset` low after 13 bits, then release and send a fresh Length=1 frame of 0x5A.
  - Expect all outputs at reset values while low, then a single 0x5A with `Byte_last`=1 and `Done`.
